// File: rtl/shifter_operand_iter_if.sv
// Request/response bundle for shifter_operand_iter: operand request in, shifter operand and carry out.
interface shifter_operand_iter_if #(
    parameter int unsigned DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_mode;
    logic              in_by_reg;
    logic [7:0]        in_amount;
    logic [DATA_W-1:0] in_data;
    logic              in_carry;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic              out_carry;

    modport master (
        output in_valid, in_mode, in_by_reg, in_amount, in_data, in_carry, out_ready,
        input  in_ready, out_valid, out_result, out_carry
    );

    modport slave (
        input  in_valid, in_mode, in_by_reg, in_amount, in_data, in_carry, out_ready,
        output in_ready, out_valid, out_result, out_carry
    );
endinterface

// File: rtl/shifter_operand_iter.sv
// Iterative data-processing shifter operand (LSL/LSR/ASR/ROR/RRX/ROT_IMM/PASS), STEP bits per cycle.
// Optional macro SHIFTER_CARRY_EN enables shifter carry-out tracking; otherwise out_carry is 0.
module shifter_operand_iter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned STEP   = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    shifter_operand_iter_if.slave  bus,
    output logic                   busy
);
    localparam int unsigned     LW       = $clog2(DATA_W);
    localparam int unsigned     CW       = $clog2(DATA_W + 1);
    localparam logic [8:0]      N9       = 9'(DATA_W);
    localparam logic [CW-1:0]   N_CNT    = CW'(DATA_W);
    localparam logic [CW-1:0]   STEP_CNT = CW'(STEP);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;
    typedef enum logic [1:0] {K_LSL, K_LSR, K_ASR, K_ROR} kind_e;
    typedef enum logic [2:0] {
        M_LSL    = 3'd0,
        M_LSR    = 3'd1,
        M_ASR    = 3'd2,
        M_ROR    = 3'd3,
        M_RRX    = 3'd4,
        M_ROTIMM = 3'd5,
        M_PASS   = 3'd6,
        M_PASS7  = 3'd7
    } mode_e;

    state_e            state_q, state_d;
    kind_e             kind_q, kind_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              sign_q, sign_d;
    logic              carry_q, carry_d;

    kind_e             dec_kind;
    logic [CW-1:0]     dec_cnt;
    logic [DATA_W-1:0] dec_data;
    logic              dec_carry;

    logic [LW-1:0]       a_mod;
    logic [8:0]          amt9;
    logic [4:0]          rot5;
    logic [LW-1:0]       rot_m;
    logic [DATA_W-1:0]   imm_ext;
    logic [2*DATA_W-1:0] rot_dbl;
    logic [DATA_W-1:0]   rot_res;

    logic [CW-1:0]     step;
    logic [DATA_W-1:0] sh_data;
    logic              sh_carry;

    assign a_mod   = bus.in_amount[LW-1:0];
    assign amt9    = {1'b0, bus.in_amount};
    assign rot5    = {bus.in_amount[3:0], 1'b0};
    assign rot_m   = LW'(rot5);
    assign imm_ext = DATA_W'(bus.in_data[7:0]);
    assign rot_dbl = {imm_ext, imm_ext} >> rot_m;
    assign rot_res = rot_dbl[DATA_W-1:0];

    // Special cases resolve here to a forced result/carry with cnt=0; regular shifts only set cnt.
    always_comb begin
        dec_kind  = K_LSL;
        dec_cnt   = '0;
        dec_data  = bus.in_data;
        dec_carry = bus.in_carry;
        case (mode_e'(bus.in_mode))
            M_LSL: begin
                dec_kind = K_LSL;
                if (!bus.in_by_reg) begin
                    dec_cnt = CW'(a_mod);
                end else if (amt9 > N9) begin
                    dec_data  = '0;
                    dec_carry = 1'b0;
                end else begin
                    dec_cnt = CW'(bus.in_amount);
                end
            end
            M_LSR: begin
                dec_kind = K_LSR;
                if (!bus.in_by_reg) begin
                    dec_cnt = (a_mod == '0) ? N_CNT : CW'(a_mod);
                end else if (amt9 > N9) begin
                    dec_data  = '0;
                    dec_carry = 1'b0;
                end else begin
                    dec_cnt = CW'(bus.in_amount);
                end
            end
            M_ASR: begin
                dec_kind = K_ASR;
                if (!bus.in_by_reg) begin
                    dec_cnt = (a_mod == '0) ? N_CNT : CW'(a_mod);
                end else begin
                    dec_cnt = (amt9 >= N9) ? N_CNT : CW'(bus.in_amount);
                end
            end
            M_ROR: begin
                dec_kind = K_ROR;
                if (!bus.in_by_reg && a_mod == '0) begin
                    dec_data  = {bus.in_carry, bus.in_data[DATA_W-1:1]};
                    dec_carry = bus.in_data[0];
                end else if (bus.in_by_reg && bus.in_amount == '0) begin
                    dec_data  = bus.in_data;
                end else if (a_mod == '0) begin
                    dec_carry = bus.in_data[DATA_W-1];
                end else begin
                    dec_cnt = CW'(a_mod);
                end
            end
            M_RRX: begin
                dec_data  = {bus.in_carry, bus.in_data[DATA_W-1:1]};
                dec_carry = bus.in_data[0];
            end
            M_ROTIMM: begin
                dec_data  = rot_res;
                dec_carry = (rot5 == '0) ? bus.in_carry : rot_res[DATA_W-1];
            end
            default: begin
                dec_data  = bus.in_data;
                dec_carry = bus.in_carry;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        carry_d  = carry_q;
        step     = '0;
        sh_data  = data_q;
        sh_carry = carry_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    kind_d  = dec_kind;
                    data_d  = dec_data;
                    cnt_d   = dec_cnt;
                    sign_d  = bus.in_data[DATA_W-1];
                    carry_d = dec_carry;
                    state_d = (dec_cnt == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                step = (cnt_q > STEP_CNT) ? STEP_CNT : cnt_q;
                for (int unsigned i = 0; i < STEP; i++) begin
                    if (CW'(i) < step) begin
                        case (kind_q)
                            K_LSL: begin
                                sh_carry = sh_data[DATA_W-1];
                                sh_data  = {sh_data[DATA_W-2:0], 1'b0};
                            end
                            K_LSR: begin
                                sh_carry = sh_data[0];
                                sh_data  = {1'b0, sh_data[DATA_W-1:1]};
                            end
                            K_ASR: begin
                                sh_carry = sh_data[0];
                                sh_data  = {sign_q, sh_data[DATA_W-1:1]};
                            end
                            default: begin
                                sh_carry = sh_data[0];
                                sh_data  = {sh_data[0], sh_data[DATA_W-1:1]};
                            end
                        endcase
                    end
                end
                data_d  = sh_data;
                carry_d = sh_carry;
                cnt_d   = cnt_q - step;
                if (cnt_d == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            kind_q  <= K_LSL;
            data_q  <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
        end
    end

`ifdef SHIFTER_CARRY_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end
`else
    // Carry path is dropped; the decode/shift carry terms are left for synthesis to prune.
    logic unused_carry;
    assign carry_q      = 1'b0;
    assign unused_carry = carry_d;
`endif

    assign bus.in_ready   = (state_q == S_IDLE) & reset_n;
    assign bus.out_valid  = (state_q == S_DONE);
    assign bus.out_result = data_q;
    assign bus.out_carry  = carry_q;
    assign busy           = (state_q != S_IDLE);
endmodule

// File: tb/tb_shifter_operand_iter.sv
// Self-checking bench for shifter_operand_iter (DATA_W=32, STEP=4) against a behavioural model.
module tb_shifter_operand_iter;
`ifdef SHIFTER_CARRY_EN
    localparam bit CARRY_ON = 1'b1;
`else
    localparam bit CARRY_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    logic busy;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   rand_done = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    shifter_operand_iter_if #(.DATA_W(32)) bus ();

    shifter_operand_iter #(.DATA_W(32), .STEP(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .busy    (busy)
    );

    typedef struct {
        logic [31:0] r;
        logic        c;
        int          k;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    bit   front_seen = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic cexp(input logic c);
        return c & CARRY_ON;
    endfunction

    // Reference shifter: result, carry and iteration count derived from the operand rules.
    function automatic void model(input logic [2:0] m, input logic br, input logic [7:0] a,
                                  input logic [31:0] d, input logic ci,
                                  output logic [31:0] r, output logic c, output int cnt);
        int s;
        logic [63:0] sx;
        logic [31:0] ie;
        r   = d;
        c   = ci;
        cnt = 0;
        sx  = {{32{d[31]}}, d};
        if (m == 3'd4 || (m == 3'd3 && !br && a[4:0] == 5'd0)) begin
            r = {ci, d[31:1]};
            c = d[0];
        end else if (m == 3'd5) begin
            s  = 2 * int'(a[3:0]);
            ie = {24'd0, d[7:0]};
            r  = (ie >> s) | (ie << (32 - s));
            c  = (s == 0) ? ci : r[31];
        end else if (m <= 3'd3 && !(br && a == 8'd0)) begin
            if (!br) begin
                s = int'(a) % 32;
                if ((m == 3'd1 || m == 3'd2) && s == 0) s = 32;
            end else begin
                s = int'(a);
            end
            case (m)
                3'd0: begin
                    if (s == 0) begin
                    end else if (s < 32) begin
                        r = d << s; c = d[32 - s]; cnt = s;
                    end else if (s == 32) begin
                        r = '0; c = d[0]; cnt = 32;
                    end else begin
                        r = '0; c = 1'b0;
                    end
                end
                3'd1: begin
                    if (s < 32) begin
                        r = d >> s; c = d[s - 1]; cnt = s;
                    end else if (s == 32) begin
                        r = '0; c = d[31]; cnt = 32;
                    end else begin
                        r = '0; c = 1'b0;
                    end
                end
                3'd2: begin
                    if (s >= 32) begin
                        r = {32{d[31]}}; c = d[31]; cnt = 32;
                    end else begin
                        r = 32'(sx >> s); c = d[s - 1]; cnt = s;
                    end
                end
                default: begin
                    s = s % 32;
                    if (s == 0) begin
                        c = d[31];
                    end else begin
                        r = (d >> s) | (d << (32 - s)); c = d[s - 1]; cnt = s;
                    end
                end
            endcase
        end
    endfunction

    // Scoreboard: every cycle the outputs matter they are compared with the queued model result.
    always @(negedge clk) begin : cmp_p
        logic [31:0] mr;
        logic        mc;
        int          mk;
        exp_t        e;
        if (!reset_n) begin
            exp_q.delete();
            front_seen = 1'b0;
        end else begin
            if (busy) chk("in_ready_while_busy", 64'(bus.in_ready), 64'd0);
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out_valid: got 1 expected 0 (t=%0t)", $time);
                end else begin
                    e = exp_q[0];
                    if (!front_seen) begin
                        chk("latency", 64'(cyc - e.acc), 64'(e.k));
                        front_seen = 1'b1;
                    end
                    chk("result", 64'(bus.out_result), 64'(e.r));
                    chk("carry", 64'(bus.out_carry), 64'(cexp(e.c)));
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        front_seen = 1'b0;
                    end
                end
            end else if (exp_q.size() > 0 && cyc > exp_q[0].acc + exp_q[0].k) begin
                total++;
                bad++;
                $display("FAIL out_valid_timeout: got 0 expected 1 (t=%0t)", $time);
                void'(exp_q.pop_front());
                front_seen = 1'b0;
            end
            if (bus.in_valid && bus.in_ready) begin
                model(bus.in_mode, bus.in_by_reg, bus.in_amount, bus.in_data, bus.in_carry, mr, mc, mk);
                e.r   = mr;
                e.c   = mc;
                e.k   = (mk + 3) / 4;
                e.acc = cyc + 1;
                exp_q.push_back(e);
            end
        end
    end

    task automatic send(input logic [2:0] m, input logic br, input logic [7:0] a,
                        input logic [31:0] d, input logic ci);
        @(posedge clk); #1;
        for (int i = 0; i < 200 && !bus.in_ready; i++) begin
            @(posedge clk); #1;
        end
        if (!bus.in_ready) chk("send_in_ready_timeout", 64'(bus.in_ready), 64'd1);
        bus.in_mode   = m;
        bus.in_by_reg = br;
        bus.in_amount = a;
        bus.in_data   = d;
        bus.in_carry  = ci;
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.in_mode   = 3'($urandom);
        bus.in_by_reg = 1'($urandom);
        bus.in_amount = 8'($urandom);
        bus.in_data   = $urandom;
        bus.in_carry  = 1'($urandom);
    endtask

    task automatic wait_valid();
        bit ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("wait_valid_timeout", 64'(bus.out_valid), 64'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && busy; i++) @(negedge clk);
        if (busy) chk("wait_idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic directed(input string nm, input logic [2:0] m, input logic br, input logic [7:0] a,
                            input logic [31:0] d, input logic ci,
                            input logic [31:0] er, input logic ec, input int ek);
        logic [31:0] mr;
        logic        mc;
        int          mk;
        model(m, br, a, d, ci, mr, mc, mk);
        chk({nm, "_model_result"}, 64'(mr), 64'(er));
        chk({nm, "_model_carry"}, 64'(mc), 64'(ec));
        chk({nm, "_model_k"}, 64'((mk + 3) / 4), 64'(ek));
        send(m, br, a, d, ci);
        wait_valid();
        chk({nm, "_dut_result"}, 64'(bus.out_result), 64'(er));
        chk({nm, "_dut_carry"}, 64'(bus.out_carry), 64'(cexp(ec)));
        wait_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] specials[6];
        specials = '{8'd0, 8'd31, 8'd32, 8'd33, 8'd64, 8'd255};
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_mode   = '0;
        bus.in_by_reg = 1'b0;
        bus.in_amount = '0;
        bus.in_data   = '0;
        bus.in_carry  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_result", 64'(bus.out_result), 64'd0);
        chk("rst_out_carry", 64'(bus.out_carry), 64'd0);
        chk("rst_in_ready_low", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready_high", 64'(bus.in_ready), 64'd1);

        directed("imm_lsl4",    3'd0, 1'b0, 8'd4,   32'h8000_0001, 1'b0, 32'h0000_0010, 1'b0, 1);
        directed("imm_lsr0",    3'd1, 1'b0, 8'd0,   32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 8);
        directed("reg_ror36",   3'd3, 1'b1, 8'd36,  32'h0000_00F1, 1'b0, 32'h1000_000F, 1'b0, 1);
        directed("reg_lsl40",   3'd0, 1'b1, 8'd40,  32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0, 0);
        directed("rrx",         3'd4, 1'b0, 8'd9,   32'h0000_0003, 1'b1, 32'h8000_0001, 1'b1, 0);
        directed("rot_imm",     3'd5, 1'b0, 8'd4,   32'h0000_00FF, 1'b0, 32'hFF00_0000, 1'b1, 0);
        directed("reg_lsl32",   3'd0, 1'b1, 8'd32,  32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 8);
        directed("reg_asr200",  3'd2, 1'b1, 8'd200, 32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b1, 8);
        directed("imm_asr0",    3'd2, 1'b0, 8'd0,   32'h7FFF_FFFF, 1'b1, 32'h0000_0000, 1'b0, 8);
        directed("reg_ror64",   3'd3, 1'b1, 8'd64,  32'h8000_0000, 1'b0, 32'h8000_0000, 1'b1, 0);
        directed("reg_lsr0",    3'd1, 1'b1, 8'd0,   32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1, 0);
        directed("imm_ror0",    3'd3, 1'b0, 8'd32,  32'h0000_0002, 1'b0, 32'h0000_0001, 1'b0, 0);
        directed("pass7",       3'd7, 1'b1, 8'd17,  32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, 1'b1, 0);

        // Backpressure, plus a second request held during DONE.
        bus.out_ready = 1'b0;
        send(3'd0, 1'b0, 8'd4, 32'h8000_0001, 1'b0);
        wait_valid();
        @(posedge clk); #1;
        bus.in_mode   = 3'd1;
        bus.in_by_reg = 1'b0;
        bus.in_amount = 8'd8;
        bus.in_data   = 32'hF0F0_F0F0;
        bus.in_carry  = 1'b0;
        bus.in_valid  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_result", 64'(bus.out_result), 64'h10);
            chk("bp_carry", 64'(bus.out_carry), 64'(cexp(1'b0)));
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_idle_busy", 64'(busy), 64'd0);
        chk("bp_idle_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_valid();
        chk("bp_second_result", 64'(bus.out_result), 64'h00F0_F0F0);
        chk("bp_second_carry", 64'(bus.out_carry), 64'(cexp(1'b1)));
        wait_idle();

        // Reset in the middle of an 8-cycle ASR.
        send(3'd2, 1'b0, 8'd0, 32'h8000_0000, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_out_result", 64'(bus.out_result), 64'd0);
        chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
        repeat (12) @(negedge clk);

        fork
            begin
                for (int n = 0; n < 250; n++) begin
                    logic [7:0]  a;
                    logic [31:0] d;
                    case ($urandom_range(0, 2))
                        0:       a = 8'($urandom);
                        1:       a = 8'($urandom_range(0, 40));
                        default: a = specials[$urandom_range(0, 5)];
                    endcase
                    d = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
                    send(3'($urandom), 1'($urandom), a, d, 1'($urandom));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        wait_idle();
        repeat (3) @(negedge clk);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
